// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encodings, byte width, default baud divisor.
package fifo_uart_pkg;

   localparam int unsigned DATA_W           = 8;
   localparam int unsigned BIT_IDX_W        = 3;
   localparam int unsigned CLKS_PER_BIT_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module baud_counter
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clear_i,
   output logic bit_done_c_o
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bit_done_c_o = en_i && (cnt_q == CNT_MAX);

   // Clearing on a state change starts every new state at count 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || bit_done_c_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a sync FIFO and serialises them as 8N1 frames.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_r_data,
   output logic              fifo_r_enable,
   output logic              tx,
   output logic              busy
);

   tx_state_e              state_q, state_d;
   logic [DATA_W-1:0]      shift_q, shift_d;
   logic [BIT_IDX_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   bit_done;
   logic                   baud_en;

   assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

   baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_counter (
      .clk          (clk),
      .reset        (reset),
      .en_i         (baud_en),
      .clear_i      (state_d != state_q),
      .bit_done_c_o (bit_done)
   );

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      fifo_r_enable = 1'b0;
      tx_d          = 1'b1;
      busy_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            fifo_r_enable = tx_enable && !fifo_empty && !reset;
            if (fifo_r_enable) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            shift_d = fifo_r_data;
            state_d = ST_START;
         end
         ST_START: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               if (bit_cnt_q == BIT_IDX_W'(DATA_W - 1)) begin
                  state_d = ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_IDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Line level is computed from the next state so tx is a clean register output.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[bit_cnt_d];
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are 2 or more.
REQ-002 Parameter: DATA_W, 8, byte width; fixed at 8 and not overridable.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: tx_enable  input  1  permits starting new frames.
REQ-006 Port: fifo_empty  input  1  empty flag from the 16x8 sync FIFO.
REQ-007 Port: fifo_r_data  input  8  FIFO read data, valid the cycle after a pop.
REQ-008 Port: fifo_r_enable  output  1  FIFO pop strobe.
REQ-009 Port: tx  output  1  serial line; idles high.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 States SHALL be IDLE, LOAD, START, DATA and STOP.
REQ-012 In IDLE, fifo_r_enable SHALL equal (tx_enable && !fifo_empty), combinationally; in all other states it SHALL be 0.
REQ-013 IDLE SHALL go to LOAD on the cycle fifo_r_enable=1; otherwise it SHALL stay in IDLE.
REQ-014 Each pop SHALL be exactly one cycle wide, with at most one pop per frame.
REQ-015 LOAD SHALL capture fifo_r_data into an 8-bit shift register and go to START.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit counter SHALL select the bit; after bit 7 it SHALL go to STOP.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 tx SHALL be 1 in IDLE and LOAD, and SHALL be registered (glitch-free).
REQ-020 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and clear on every state change.
REQ-021 Latency: if a pop occurs at cycle 0, tx SHALL fall at cycle 2, and the state SHALL return to IDLE at cycle 2+10*CLKS_PER_BIT.
REQ-022 With the FIFO continuously non-empty, frame starts SHALL be spaced exactly 10*CLKS_PER_BIT+2 cycles apart.
REQ-023 If tx_enable deasserts mid-frame, the current frame SHALL complete, and no pop SHALL occur while tx_enable is low.
REQ-024 A fifo_empty change during LOAD, START, DATA or STOP SHALL have no effect.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, tx=1, busy=0, counters=0, shift register=0.
REQ-026 fifo_r_enable SHALL be 0 in any cycle where reset=1.
REQ-027 Reset mid-frame SHALL abort the frame: tx=1 from the next cycle, and the popped byte is discarded (not re-read).

Structure
REQ-028 A shared package fifo_uart_pkg SHALL hold the state encodings (3-bit), DATA_W and the default CLKS_PER_BIT.
REQ-029 One sub-module, baud_counter, SHALL implement the per-bit cycle counter and emit a bit_done pulse.
REQ-030 The shift register and the FSM SHALL reside in fifo_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset check: hold reset 3 cycles -> tx=1, busy=0, fifo_r_enable=0 throughout.
REQ-032 Single byte: FIFO holds 0xA5 and empty drops at cycle 0.
- fifo_r_enable=1 at cycle 0 only.
- tx=0 during cycles 2-5.
- Data bits 1,0,1,0,0,1,0,1 follow, 4 cycles each.
- Stop bit: tx=1 during cycles 38-41.
- busy=0 at cycle 42.
REQ-033 Back-to-back: FIFO holds 0x00 then 0xFF -> second start bit begins exactly 42 cycles after the first; the second pop occurs at cycle 42.
REQ-034 Empty FIFO: fifo_empty=1 and tx_enable=1 for 200 cycles -> fifo_r_enable never asserted, tx stays 1.
REQ-035 Reset mid-frame: 1-cycle reset during data bit 3 -> tx=1 and busy=0 the next cycle, with no pop in that cycle.
REQ-036 Gating: tx_enable drops during frame 1 with the FIFO non-empty -> frame 1 completes, no pop while tx_enable is low; the pop occurs on the cycle tx_enable returns.
